// File: rtl/eluks_pkg.sv
// Shared definitions for the eLUKS Wishbone arbiter: FSM state encoding and master indices.
package eluks_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn  = 2'd1,
    StTerm = 2'd2
  } arb_state_e;

  localparam int unsigned BOOT_M = 0;
  localparam int unsigned CPU_M  = 1;
  localparam int unsigned NUM_M  = 2;

  function automatic logic [NUM_M-1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts consecutive stalled strobe cycles; flags when the count has reached TIMEOUT.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned CW     = $clog2(TIMEOUT + 1)
) (
  input  logic wb_clk,
  input  logic rst,
  input  logic inc,
  output logic expired
);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == CW'(TIMEOUT));

  // Any non-stalled cycle restarts the count; hold at TIMEOUT rather than wrap.
  always_comb begin
    count_d = '0;
    if (inc) begin
      count_d = expired ? count_q : count_q + CW'(1);
    end
  end

  always_ff @(posedge wb_clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/eluks_wb_arbiter.sv
// Two-master Wishbone arbiter (bootloader / CPU) with round-robin tie-break and stall timeout.
module eluks_wb_arbiter
  import eluks_pkg::*;
#(
  parameter int unsigned WB_DATA = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       wb_clk,
  input  logic                       rst,
  input  logic [1:0]                 m_cyc_i,
  input  logic [1:0]                 m_stb_i,
  input  logic [1:0]                 m_we_i,
  input  logic [2*(WB_DATA/8)-1:0]   m_sel_i,
  input  logic [2*WB_DATA-1:0]       m_adr_i,
  input  logic [2*WB_DATA-1:0]       m_dat_i,
  output logic [1:0]                 m_ack_o,
  output logic [1:0]                 m_err_o,
  output logic [WB_DATA-1:0]         m_dat_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [WB_DATA/8-1:0]       s_sel_o,
  output logic [WB_DATA-1:0]         s_adr_o,
  output logic [WB_DATA-1:0]         s_dat_o,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  input  logic [WB_DATA-1:0]         s_dat_i,
  output logic [1:0]                 grant_o,
  output logic                       timeout_o
);

  localparam int unsigned SelW = WB_DATA / 8;

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       timeout_q, timeout_d;
  logic       winner;
  logic       tmo_inc, tmo_expired;

  logic               sel_cyc, sel_stb, sel_we;
  logic [SelW-1:0]    sel_sel;
  logic [WB_DATA-1:0] sel_adr, sel_dat;

  // Slice of the current owner's request bus.
  always_comb begin
    sel_cyc = m_cyc_i[owner_q];
    sel_stb = m_stb_i[owner_q];
    sel_we  = m_we_i[owner_q];
    if (owner_q) begin
      sel_sel = m_sel_i[CPU_M*SelW +: SelW];
      sel_adr = m_adr_i[CPU_M*WB_DATA +: WB_DATA];
      sel_dat = m_dat_i[CPU_M*WB_DATA +: WB_DATA];
    end else begin
      sel_sel = m_sel_i[BOOT_M*SelW +: SelW];
      sel_adr = m_adr_i[BOOT_M*WB_DATA +: WB_DATA];
      sel_dat = m_dat_i[BOOT_M*WB_DATA +: WB_DATA];
    end
  end

  // Lone requester wins; a tie goes to whoever did not win last time.
  always_comb begin
    case (m_cyc_i)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = timeout_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    grant_o   = '0;

    unique case (state_q)
      StIdle: begin
        if (|m_cyc_i) begin
          state_d = StOwn;
          owner_d = winner;
          last_d  = winner;
        end
      end
      StOwn: begin
        grant_o = owner_onehot(owner_q);
        s_we_o  = sel_we;
        s_sel_o = sel_sel;
        s_adr_o = sel_adr;
        s_dat_o = sel_dat;
        // A slave termination in the expiry cycle takes precedence over the timeout.
        if (tmo_expired && !s_ack_i && !s_err_i) begin
          m_err_o[owner_q] = 1'b1;
          timeout_d        = 1'b1;
          state_d          = StTerm;
        end else begin
          s_cyc_o          = sel_cyc;
          s_stb_o          = sel_stb;
          m_ack_o[owner_q] = s_ack_i;
          m_err_o[owner_q] = s_err_i;
          if (!sel_cyc) begin
            state_d = StIdle;
          end
        end
      end
      StTerm: begin
        grant_o = owner_onehot(owner_q);
        if (!sel_cyc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tmo_inc   = (state_q == StOwn) && s_stb_o && !s_ack_i && !s_err_i;
  assign timeout_o = timeout_q;
  // Read data is broadcast, but kept quiet while reset is held.
  assign m_dat_o   = rst ? '0 : s_dat_i;

  wb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .wb_clk (wb_clk),
    .rst    (rst),
    .inc    (tmo_inc),
    .expired(tmo_expired)
  );

  always_ff @(posedge wb_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_eluks_wb_arbiter.sv
// Bench for eluks_wb_arbiter: directed scenarios with literal expectations plus random traffic
// checked every cycle against a transaction-level model.
module tb_eluks_wb_arbiter;

  localparam int unsigned WB_DATA = 32;
  localparam int unsigned TIMEOUT = 8;

  logic        wb_clk, rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [7:0]  m_sel;
  logic [63:0] m_adr, m_dat;
  logic [1:0]  m_ack, m_err, grant;
  logic [31:0] m_dat_o, s_adr, s_dat_o, s_dat;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, timeout;
  logic [3:0]  s_sel;

  int checks = 0;
  int errors = 0;

  eluks_wb_arbiter #(
    .WB_DATA(WB_DATA),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk   (wb_clk),
    .rst      (rst),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_sel_i  (m_sel),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .m_dat_o  (m_dat_o),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat_o),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .s_dat_i  (s_dat),
    .grant_o  (grant),
    .timeout_o(timeout)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  // Model: who owns the bus, whether the tenure has been killed by a timeout,
  // how many stalled strobe cycles have elapsed, and the round-robin memory.
  int owner_m = -1;
  bit killed_m = 0;
  bit last_m = 1;
  bit tmo_m = 0;
  int stalled_m = 0;

  always @(negedge wb_clk) begin : model
    logic [1:0]  e_ack, e_err, e_grant;
    logic        e_cyc, e_stb, e_we, hit;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat, e_mdat;
    int          w;
    e_ack = 0; e_err = 0; e_grant = 0; e_cyc = 0; e_stb = 0; e_we = 0;
    e_sel = 0; e_adr = 0; e_dat = 0; hit = 0;
    e_mdat = rst ? 32'h0 : s_dat;
    if (!rst && owner_m >= 0) begin
      e_grant = (owner_m == 1) ? 2'b10 : 2'b01;
      if (!killed_m) begin
        e_we  = m_we[owner_m];
        e_sel = m_sel[owner_m*4 +: 4];
        e_adr = m_adr[owner_m*32 +: 32];
        e_dat = m_dat[owner_m*32 +: 32];
        hit = (stalled_m >= TIMEOUT) && !s_ack && !s_err;
        if (hit) begin
          e_err[owner_m] = 1'b1;
        end else begin
          e_cyc = m_cyc[owner_m];
          e_stb = m_stb[owner_m];
          e_ack[owner_m] = s_ack;
          e_err[owner_m] = s_err;
        end
      end
    end
    chk("mdl_grant", grant, e_grant);
    chk("mdl_s_cyc", s_cyc, e_cyc);
    chk("mdl_s_stb", s_stb, e_stb);
    chk("mdl_s_we", s_we, e_we);
    chk("mdl_s_sel", s_sel, e_sel);
    chk("mdl_s_adr", s_adr, e_adr);
    chk("mdl_s_dat", s_dat_o, e_dat);
    chk("mdl_m_ack", m_ack, e_ack);
    chk("mdl_m_err", m_err, e_err);
    chk("mdl_m_dat", m_dat_o, e_mdat);
    chk("mdl_timeout", timeout, rst ? 1'b0 : tmo_m);

    // Advance to what the next clock edge must produce.
    if (rst) begin
      owner_m = -1; killed_m = 0; last_m = 1; tmo_m = 0; stalled_m = 0;
    end else if (owner_m < 0) begin
      if (m_cyc != 2'b00) begin
        w = (m_cyc == 2'b11) ? int'(!last_m) : int'(m_cyc[1]);
        owner_m = w;
        last_m = w[0];
        stalled_m = 0;
      end
    end else if (killed_m) begin
      if (!m_cyc[owner_m]) begin
        owner_m = -1;
        killed_m = 0;
      end
    end else if (hit) begin
      killed_m = 1;
      tmo_m = 1;
      stalled_m = 0;
    end else if (!m_cyc[owner_m]) begin
      owner_m = -1;
      stalled_m = 0;
    end else begin
      stalled_m = (m_stb[owner_m] && !s_ack && !s_err) ? stalled_m + 1 : 0;
    end
  end

  initial begin
    bit quiet;
    rst = 1; m_cyc = 0; m_stb = 0; m_we = 0; m_sel = 0; m_adr = 0; m_dat = 0;
    s_ack = 0; s_err = 0; s_dat = 32'h0;

    // Reset state
    step(); step(); #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    step(); rst = 0;
    step();

    // One-cycle grant latency for a lone bootloader request
    step(); m_cyc = 2'b01; m_stb = 2'b01; m_adr[31:0] = 32'h92000006; m_sel = 8'h0f;
    #3; chk("latency_idle_s_cyc", s_cyc, 1'b0);
    step(); #3;
    chk("grant_s_cyc", s_cyc, 1'b1);
    chk("grant_s_adr", s_adr, 32'h92000006);
    chk("grant_onehot", grant, 2'b01);

    // CPU requests while bootloader owns; ack goes to bootloader only
    step(); m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1; #3;
    chk("ack_route", m_ack, 2'b01);
    chk("no_preempt", grant, 2'b01);
    step(); s_ack = 0; m_cyc = 2'b10; m_stb = 2'b10; #3;
    chk("release_s_cyc", s_cyc, 1'b0);
    step(); #3; chk("handover_gap", grant, 2'b00);
    step(); #3; chk("handover_cpu", grant, 2'b10);
    step(); m_cyc = 0; m_stb = 0;
    step(); rst = 1;
    step(); rst = 0;

    // Tie after reset goes to master 0, then round-robin to master 1
    step(); m_cyc = 2'b11; m_stb = 2'b11;
    step(); #3; chk("tie_boot", grant, 2'b01);
    step(); m_cyc = 2'b10; m_stb = 2'b10;
    step(); m_cyc = 2'b11; m_stb = 2'b11; #3; chk("tie_gap", grant, 2'b00);
    step(); #3; chk("tie_cpu", grant, 2'b10);
    step(); m_cyc = 0; m_stb = 0;
    step();

    // Ack on the expiry cycle wins over the timeout
    step(); m_cyc = 2'b01; m_stb = 2'b01;
    step();
    for (int i = 0; i < TIMEOUT; i++) begin
      #3; chk("late_pre_err", m_err, 2'b00);
      step();
    end
    s_ack = 1; #3;
    chk("late_ack", m_ack, 2'b01);
    chk("late_err", m_err, 2'b00);
    chk("late_s_cyc", s_cyc, 1'b1);
    step(); s_ack = 0; m_cyc = 0; m_stb = 0; #3;
    chk("late_timeout", timeout, 1'b0);
    step(); step();

    // Stall past TIMEOUT cycles
    step(); m_cyc = 2'b01; m_stb = 2'b01;
    step();
    for (int i = 0; i < TIMEOUT; i++) begin
      #3; chk("tmo_pre_err", m_err, 2'b00); chk("tmo_pre_s_cyc", s_cyc, 1'b1);
      step();
    end
    #3;
    chk("tmo_err", m_err, 2'b01);
    chk("tmo_drop_s_cyc", s_cyc, 1'b0);
    step(); #3;
    chk("tmo_flag", timeout, 1'b1);
    chk("term_s_cyc", s_cyc, 1'b0);
    chk("term_grant", grant, 2'b01);
    chk("term_err_pulse", m_err, 2'b00);
    step(); #3; chk("term_hold", grant, 2'b01);
    step(); m_cyc = 0; m_stb = 0;
    step(); #3;
    chk("term_exit", grant, 2'b00);
    chk("tmo_sticky", timeout, 1'b1);

    // Asynchronous reset in the middle of a write
    step(); m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_dat[31:0] = 32'hdeadbeef;
    step(); s_ack = 1; s_dat = 32'h12345678; #1;
    chk("pre_rst_ack", m_ack, 2'b01);
    rst = 1; #1;
    chk("arst_grant", grant, 2'b00);
    chk("arst_s_cyc", s_cyc, 1'b0);
    chk("arst_s_we", s_we, 1'b0);
    chk("arst_s_dat", s_dat_o, 32'h0);
    chk("arst_m_ack", m_ack, 2'b00);
    chk("arst_m_err", m_err, 2'b00);
    chk("arst_m_dat", m_dat_o, 32'h0);
    chk("arst_timeout", timeout, 1'b0);
    step();
    step(); rst = 0; s_ack = 0; m_we = 0; m_cyc = 2'b11; m_stb = 2'b11;
    step(); #3; chk("post_rst_tie", grant, 2'b01);
    step(); m_cyc = 0; m_stb = 0;
    step();

    // Random traffic, checked by the model every cycle
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n % 64 == 0) quiet = ($urandom_range(0, 2) == 0);
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 9) < 3) m_cyc[m] = ~m_cyc[m];
        m_stb[m] = m_cyc[m] & ($urandom_range(0, 3) != 0);
        m_we[m]  = 1'($urandom);
      end
      m_sel = 8'($urandom);
      m_adr = {$urandom, $urandom};
      m_dat = {$urandom, $urandom};
      s_dat = $urandom;
      s_ack = !quiet && ($urandom_range(0, 3) == 0);
      s_err = !quiet && !s_ack && ($urandom_range(0, 19) == 0);
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
